// File: rtl/data_mem_resp_if.sv
// Core-side data bus of the wait-stated data memory: request in, ack/err/data out.
interface data_mem_resp_if;
   logic [31:0] d_addr_i;
   logic [31:0] d_data_i;
   logic        d_rd_i;
   logic        d_wr_i;
   logic [31:0] d_data_o;
   logic        d_ack_o;
   logic        d_err_o;
   logic        busy_o;

   // Core side: issues requests, receives completion.
   modport master (
      output d_addr_i, d_data_i, d_rd_i, d_wr_i,
      input  d_data_o, d_ack_o, d_err_o, busy_o
   );

   // Memory side: receives requests, returns completion.
   modport slave (
      input  d_addr_i, d_data_i, d_rd_i, d_wr_i,
      output d_data_o, d_ack_o, d_err_o, busy_o
   );
endinterface

// File: rtl/data_mem_resp.sv
// Single-port data memory with a programmable number of wait states.
// One access executes per edge; the result is acked for exactly one cycle,
// with an error pulse for misaligned, out-of-range or rd+wr requests.
module data_mem_resp #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input logic            clk_i,
   input logic            rst_n_i,
   data_mem_resp_if.slave bus
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_next;
   logic [3:0]  cnt, cnt_next;

   // request captured at accept
   logic [31:0] lat_addr;
   logic [31:0] lat_data;
   logic        lat_rd;
   logic        lat_wr;

   // values of the access executing on the current edge
   logic        exec;
   logic [31:0] ex_addr;
   logic [31:0] ex_data;
   logic        ex_rd;
   logic        ex_wr;
   logic        ex_err;
   logic [AW-1:0] ex_idx;

   logic        req;
   logic        accept;
   logic        mem_we;

   logic [31:0] rdata;
   logic        ack;
   logic        err;

   logic [31:0] mem [DEPTH_WORDS];

   assign req    = bus.d_rd_i | bus.d_wr_i;
   assign accept = ((state == IDLE) || (state == RESP)) && req;

   // With wait states the access runs from the latched copy in WAIT; with
   // none it runs on the accept edge itself, straight from the bus.
   assign ex_addr = (state == WAIT) ? lat_addr : bus.d_addr_i;
   assign ex_data = (state == WAIT) ? lat_data : bus.d_data_i;
   assign ex_rd   = (state == WAIT) ? lat_rd   : bus.d_rd_i;
   assign ex_wr   = (state == WAIT) ? lat_wr   : bus.d_wr_i;

   // BASE_ADDR is aligned to the memory size, so the range test is an
   // upper-bit compare and the word index is just the low address bits.
   assign ex_err = (ex_addr[1:0] != 2'b00)
                 | (ex_addr[31:AW+2] != BASE_ADDR[31:AW+2])
                 | (ex_rd & ex_wr);
   assign ex_idx = ex_addr[AW+1:2];

   // Gated by reset so a request held during reset can never write.
   assign mem_we = exec & rst_n_i & ex_wr & ~ex_err;

   // Next-state logic: accept from IDLE/RESP, count down wait states, execute.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      exec       = 1'b0;
      case (state)
         IDLE, RESP: begin
            if (req) begin
               if (WAIT_STATES > 0) begin
                  state_next = WAIT;
                  cnt_next   = CNT_LOAD;
               end else begin
                  state_next = RESP;
                  exec       = 1'b1;
               end
            end else begin
               state_next = IDLE;
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               state_next = RESP;
               exec       = 1'b1;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State, request latch and registered response; reset aborts any access.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         lat_addr <= 32'd0;
         lat_data <= 32'd0;
         lat_rd   <= 1'b0;
         lat_wr   <= 1'b0;
         rdata    <= 32'd0;
         ack      <= 1'b0;
         err      <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         ack   <= exec;
         err   <= exec & ex_err;
         if (accept) begin
            lat_addr <= bus.d_addr_i;
            lat_data <= bus.d_data_i;
            lat_rd   <= bus.d_rd_i;
            lat_wr   <= bus.d_wr_i;
         end
         if (exec) begin
            if (ex_err) begin
               rdata <= 32'd0;
            end else if (ex_rd) begin
               rdata <= mem[ex_idx];
            end
         end
      end
   end

   // Storage array; contents are deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem[ex_idx] <= ex_data;
      end
   end

   assign bus.d_data_o = rdata;
   assign bus.d_ack_o  = ack;
   assign bus.d_err_o  = err;
   assign bus.busy_o   = (state == WAIT);

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: three instances with 1, 0 and 3 wait states.
module tb_data_mem_resp;

   logic clk;
   logic rst_n;
   logic rst3_n;
   int   n_cmp;
   int   n_bad;

   data_mem_resp_if if_ws1 ();
   data_mem_resp_if if_ws0 ();
   data_mem_resp_if if_ws3 ();

   data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_ws1 (
      .clk_i(clk), .rst_n_i(rst_n), .bus(if_ws1));
   data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
      .clk_i(clk), .rst_n_i(rst_n), .bus(if_ws0));
   data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_ws3 (
      .clk_i(clk), .rst_n_i(rst3_n), .bus(if_ws3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // w: 0 = one wait state, 1 = zero wait states, 2 = three wait states
   task automatic drive(input int w, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data);
      case (w)
         0: begin if_ws1.d_rd_i = rd; if_ws1.d_wr_i = wr; if_ws1.d_addr_i = addr; if_ws1.d_data_i = data; end
         1: begin if_ws0.d_rd_i = rd; if_ws0.d_wr_i = wr; if_ws0.d_addr_i = addr; if_ws0.d_data_i = data; end
         default: begin if_ws3.d_rd_i = rd; if_ws3.d_wr_i = wr; if_ws3.d_addr_i = addr; if_ws3.d_data_i = data; end
      endcase
   endtask

   function automatic logic ack_of(input int w);
      case (w)
         0: return if_ws1.d_ack_o;
         1: return if_ws0.d_ack_o;
         default: return if_ws3.d_ack_o;
      endcase
   endfunction

   function automatic logic err_of(input int w);
      case (w)
         0: return if_ws1.d_err_o;
         1: return if_ws0.d_err_o;
         default: return if_ws3.d_err_o;
      endcase
   endfunction

   function automatic logic busy_of(input int w);
      case (w)
         0: return if_ws1.busy_o;
         1: return if_ws0.busy_o;
         default: return if_ws3.busy_o;
      endcase
   endfunction

   function automatic logic [31:0] data_of(input int w);
      case (w)
         0: return if_ws1.d_data_o;
         1: return if_ws0.d_data_o;
         default: return if_ws3.d_data_o;
      endcase
   endfunction

   // Wait (bounded) for the ack, check latency in edges counted from the call,
   // release the request during the ack cycle, then confirm the ack was one pulse.
   task automatic finish_req(input int w, input int exp_lat, input string tag,
                             output logic [31:0] rdata, output logic rerr);
      int  n;
      bit  got;
      n   = 0;
      got = 0;
      while (!got && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1 && exp_lat > 1) check({tag, ":busy"}, 64'(busy_of(w)), 64'd1);
         if (ack_of(w)) got = 1;
      end
      check({tag, ":latency"}, 64'(n), 64'(exp_lat));
      rdata = data_of(w);
      rerr  = err_of(w);
      drive(w, 1'b0, 1'b0, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      check({tag, ":ack_pulse"}, 64'(ack_of(w)), 64'd0);
   endtask

   task automatic access(input int w, input int exp_lat, input string tag,
                         input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic exp_err,
                         input bit chk_data, input logic [31:0] exp_data);
      logic [31:0] rdata;
      logic        rerr;
      drive(w, rd, wr, addr, data);
      finish_req(w, exp_lat, tag, rdata, rerr);
      check({tag, ":err"}, 64'(rerr), 64'(exp_err));
      if (chk_data) check({tag, ":data"}, 64'(rdata), 64'(exp_data));
   endtask

   logic [31:0] rd_tmp;
   logic        err_tmp;

   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      rst_n  = 1'b1;
      rst3_n = 1'b1;
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
      #2;
      rst_n  = 1'b0;
      rst3_n = 1'b0;
      #1;
      // reset state of all instances
      for (int w = 0; w < 3; w++) begin
         check("reset:flags", {61'd0, ack_of(w), err_of(w), busy_of(w)}, 64'd0);
         check("reset:data", 64'(data_of(w)), 64'd0);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      rst3_n = 1'b1;

      // one wait state: write then read back, latency 2
      access(0, 2, "ws1_wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 0, 32'd0);
      access(0, 2, "ws1_rd10", 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1, 32'hDEADBEEF);
      // a write leaves the read data register alone
      access(0, 2, "ws1_wr14", 1'b0, 1'b1, 32'h14, 32'h01020304, 1'b0, 1, 32'hDEADBEEF);

      // error cases
      access(0, 2, "ws1_wr0", 1'b0, 1'b1, 32'h0, 32'hA0A0A0A0, 1'b0, 0, 32'd0);
      access(0, 2, "ws1_wr4", 1'b0, 1'b1, 32'h4, 32'hB1B1B1B1, 1'b0, 0, 32'd0);
      access(0, 2, "ws1_rd4", 1'b1, 1'b0, 32'h4, 32'd0, 1'b0, 1, 32'hB1B1B1B1);
      access(0, 2, "ws1_rd6_mis", 1'b1, 1'b0, 32'h6, 32'd0, 1'b1, 1, 32'd0);
      access(0, 2, "ws1_rd14", 1'b1, 1'b0, 32'h14, 32'd0, 1'b0, 1, 32'h01020304);
      access(0, 2, "ws1_rd_oor", 1'b1, 1'b0, 32'h1000, 32'd0, 1'b1, 1, 32'd0);
      access(0, 2, "ws1_wr6_mis", 1'b0, 1'b1, 32'h6, 32'hFFFFFFFF, 1'b1, 0, 32'd0);
      access(0, 2, "ws1_chk4", 1'b1, 1'b0, 32'h4, 32'd0, 1'b0, 1, 32'hB1B1B1B1);
      access(0, 2, "ws1_chk0", 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 1, 32'hA0A0A0A0);
      access(0, 2, "ws1_wr20", 1'b0, 1'b1, 32'h20, 32'h88888888, 1'b0, 0, 32'd0);
      access(0, 2, "ws1_rdwr20", 1'b1, 1'b1, 32'h20, 32'h0, 1'b1, 1, 32'd0);
      access(0, 2, "ws1_chk20", 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 1, 32'h88888888);

      // zero wait states: preload, then back-to-back reads
      access(1, 1, "ws0_wr0", 1'b0, 1'b1, 32'h0, 32'h11111111, 1'b0, 0, 32'd0);
      access(1, 1, "ws0_wr4", 1'b0, 1'b1, 32'h4, 32'h22222222, 1'b0, 0, 32'd0);
      access(1, 1, "ws0_wr8", 1'b0, 1'b1, 32'h8, 32'h33333333, 1'b0, 0, 32'd0);
      drive(1, 1'b1, 1'b0, 32'h0, 32'd0);
      @(posedge clk);
      #1;
      check("ws0_b2b0:ack", 64'(ack_of(1)), 64'd1);
      check("ws0_b2b0:data", 64'(data_of(1)), 64'h11111111);
      drive(1, 1'b1, 1'b0, 32'h4, 32'd0);
      @(posedge clk);
      #1;
      check("ws0_b2b1:ack", 64'(ack_of(1)), 64'd1);
      check("ws0_b2b1:data", 64'(data_of(1)), 64'h22222222);
      drive(1, 1'b1, 1'b0, 32'h8, 32'd0);
      @(posedge clk);
      #1;
      check("ws0_b2b2:ack", 64'(ack_of(1)), 64'd1);
      check("ws0_b2b2:data", 64'(data_of(1)), 64'h33333333);
      check("ws0_b2b2:busy", 64'(busy_of(1)), 64'd0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'd0);
      @(posedge clk);
      #1;
      check("ws0_b2b_end:ack", 64'(ack_of(1)), 64'd0);
      check("ws0_b2b_end:data", 64'(data_of(1)), 64'h33333333);

      // three wait states: prior value, then a write aborted by reset
      access(2, 4, "ws3_wr40", 1'b0, 1'b1, 32'h40, 32'h0BADF00D, 1'b0, 0, 32'd0);
      access(2, 4, "ws3_rd40", 1'b1, 1'b0, 32'h40, 32'd0, 1'b0, 1, 32'h0BADF00D);
      drive(2, 1'b0, 1'b1, 32'h40, 32'h12345678);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("ws3_abort:busy_before", 64'(busy_of(2)), 64'd1);
      rst3_n = 1'b0;
      #1;
      check("ws3_abort:flags", {61'd0, ack_of(2), err_of(2), busy_of(2)}, 64'd0);
      check("ws3_abort:data", 64'(data_of(2)), 64'd0);
      drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("ws3_abort:no_ack", 64'(ack_of(2)), 64'd0);
      end
      rst3_n = 1'b1;
      access(2, 4, "ws3_rd40_after", 1'b1, 1'b0, 32'h40, 32'd0, 1'b0, 1, 32'h0BADF00D);

      // bus changes during WAIT are ignored
      access(2, 4, "ws3_wr48", 1'b0, 1'b1, 32'h48, 32'h48484848, 1'b0, 0, 32'd0);
      drive(2, 1'b0, 1'b1, 32'h44, 32'hAAAA5555);
      @(posedge clk);
      #1;
      drive(2, 1'b0, 1'b1, 32'h48, 32'h00000000);
      finish_req(2, 3, "ws3_wr44_chg", rd_tmp, err_tmp);
      check("ws3_wr44_chg:err", 64'(err_tmp), 64'd0);
      access(2, 4, "ws3_rd44", 1'b1, 1'b0, 32'h44, 32'd0, 1'b0, 1, 32'hAAAA5555);
      access(2, 4, "ws3_rd48", 1'b1, 1'b0, 32'h48, 32'd0, 1'b0, 1, 32'h48484848);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
